// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multi-cycle control sequencer: state enum, opcode map,
// datapath select encodings and the packed per-cycle control word.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WB,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_ALU_WB,
      S_HALT,
      S_TRAP
   } state_e;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_ADDI  = 4'h1;
   localparam logic [3:0] OP_LW    = 4'h2;
   localparam logic [3:0] OP_SW    = 4'h3;
   localparam logic [3:0] OP_BEQ   = 4'h4;
   localparam logic [3:0] OP_J     = 4'h5;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_REG = 2'b00;
   localparam logic [1:0] SRCB_ONE = 2'b01;
   localparam logic [1:0] SRCB_IMM = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcWrite;
      logic       pcWriteCond;
      logic       iorD;
      logic       memRead;
      logic       memWrite;
      logic       irWrite;
      logic       memToReg;
      logic       regDst;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] aluOp;
      logic [1:0] pcSource;
      logic       halted;
      logic       trap;
   } ctrl_word_t;

   // States whose exit to FETCH retires an instruction.
   function automatic logic endsInstr(input state_e s);
      return (s == S_ALU_WB) || (s == S_MEM_WB) || (s == S_MEM_WR) ||
             (s == S_BRANCH) || (s == S_JUMP);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational control-word decode of the sequencer state; only FETCH
// has Mealy terms (IRWrite/PCWrite gated by memory ready).
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  state_e     state_i,
   input  logic       memReady_i,
   input  logic       regDst_i,
   output ctrl_word_t ctrl_o
);

   always_comb begin
      ctrl_o = '0;
      case (state_i)
         S_FETCH: begin
            ctrl_o.memRead  = 1'b1;
            ctrl_o.iorD     = 1'b0;
            ctrl_o.aluSrcA  = 1'b0;
            ctrl_o.aluSrcB  = SRCB_ONE;
            ctrl_o.aluOp    = ALUOP_ADD;
            ctrl_o.pcSource = PCSRC_ALU;
            ctrl_o.irWrite  = memReady_i;
            ctrl_o.pcWrite  = memReady_i;
         end
         S_DECODE: begin
            ctrl_o.aluSrcB = SRCB_IMM;
            ctrl_o.aluOp   = ALUOP_ADD;
         end
         S_EXEC_R: begin
            ctrl_o.aluSrcA = 1'b1;
            ctrl_o.aluSrcB = SRCB_REG;
            ctrl_o.aluOp   = ALUOP_FUNCT;
         end
         S_EXEC_I, S_MEM_ADDR: begin
            ctrl_o.aluSrcA = 1'b1;
            ctrl_o.aluSrcB = SRCB_IMM;
            ctrl_o.aluOp   = ALUOP_ADD;
         end
         S_ALU_WB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.regDst   = regDst_i;
         end
         S_MEM_RD: begin
            ctrl_o.memRead = 1'b1;
            ctrl_o.iorD    = 1'b1;
         end
         S_MEM_WB: begin
            ctrl_o.regWrite = 1'b1;
            ctrl_o.memToReg = 1'b1;
         end
         S_MEM_WR: begin
            ctrl_o.memWrite = 1'b1;
            ctrl_o.iorD     = 1'b1;
         end
         S_BRANCH: begin
            ctrl_o.aluSrcA     = 1'b1;
            ctrl_o.aluSrcB     = SRCB_REG;
            ctrl_o.aluOp       = ALUOP_SUB;
            ctrl_o.pcWriteCond = 1'b1;
            ctrl_o.pcSource    = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctrl_o.pcWrite  = 1'b1;
            ctrl_o.pcSource = PCSRC_JUMP;
         end
         S_HALT:  ctrl_o.halted = 1'b1;
         S_TRAP:  ctrl_o.trap   = 1'b1;
         default: ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle CPU control sequencer (Moore FSM with sticky HALT/TRAP).
// Define MCCTRL_PERF_CNT_EN to build the cycle/instruction counters.
module multicycle_ctrl_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 32
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                Mem_Ready,
   output logic                PCWrite,
   output logic                PCWriteCond,
   output logic                IorD,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                IRWrite,
   output logic                MemToReg,
   output logic                RegDst,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ALUOp,
   output logic [1:0]          PCSource,
   output logic                Halted,
   output logic                Trap,
   output logic [CNT_W-1:0]    Cycle_Count,
   output logic [CNT_W-1:0]    Instr_Count
);

   state_e     state_q, state_d;
   logic       isLoad_q, isLoad_d;
   logic       regDst_q, regDst_d;
   logic       opHigh;
   ctrl_word_t ctrl;

   // Any bit above the 4-bit opcode map makes the instruction illegal.
   assign opHigh = |(Opcode >> 4);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= S_IDLE;
         isLoad_q <= 1'b0;
         regDst_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         isLoad_q <= isLoad_d;
         regDst_q <= regDst_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      isLoad_d = isLoad_q;
      regDst_d = regDst_q;
      case (state_q)
         S_IDLE:   state_d = S_FETCH;
         S_FETCH:  if (Mem_Ready) state_d = S_DECODE;
         S_DECODE: begin
            if (opHigh) begin
               state_d = S_TRAP;
            end else begin
               case (Opcode[3:0])
                  OP_RTYPE: begin state_d = S_EXEC_R;   regDst_d = 1'b1; end
                  OP_ADDI:  begin state_d = S_EXEC_I;   regDst_d = 1'b0; end
                  OP_LW:    begin state_d = S_MEM_ADDR; isLoad_d = 1'b1; end
                  OP_SW:    begin state_d = S_MEM_ADDR; isLoad_d = 1'b0; end
                  OP_BEQ:   state_d = S_BRANCH;
                  OP_J:     state_d = S_JUMP;
                  OP_HALT:  state_d = S_HALT;
                  default:  state_d = S_TRAP;
               endcase
            end
         end
         S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
         S_MEM_ADDR: state_d = isLoad_q ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD:   if (Mem_Ready) state_d = S_MEM_WB;
         S_MEM_WR:   if (Mem_Ready) state_d = S_FETCH;
         S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
         S_HALT, S_TRAP: state_d = state_q;
         default: state_d = S_IDLE;
      endcase
   end

   mc_ctrl_decode uDecode (
      .state_i    (state_q),
      .memReady_i (Mem_Ready),
      .regDst_i   (regDst_q),
      .ctrl_o     (ctrl)
   );

   assign PCWrite     = ctrl.pcWrite;
   assign PCWriteCond = ctrl.pcWriteCond;
   assign IorD        = ctrl.iorD;
   assign MemRead     = ctrl.memRead;
   assign MemWrite    = ctrl.memWrite;
   assign IRWrite     = ctrl.irWrite;
   assign MemToReg    = ctrl.memToReg;
   assign RegDst      = ctrl.regDst;
   assign RegWrite    = ctrl.regWrite;
   assign ALUSrcA     = ctrl.aluSrcA;
   assign ALUSrcB     = ctrl.aluSrcB;
   assign ALUOp       = ctrl.aluOp;
   assign PCSource    = ctrl.pcSource;
   assign Halted      = ctrl.halted;
   assign Trap        = ctrl.trap;

`ifdef MCCTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycleCnt_q;
   logic [CNT_W-1:0] instrCnt_q;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         cycleCnt_q <= '0;
         instrCnt_q <= '0;
      end else begin
         if (state_q != S_IDLE && state_q != S_HALT && state_q != S_TRAP)
            cycleCnt_q <= cycleCnt_q + CNT_W'(1);
         if (state_d == S_FETCH && endsInstr(state_q))
            instrCnt_q <= instrCnt_q + CNT_W'(1);
      end
   end

   assign Cycle_Count = cycleCnt_q;
   assign Instr_Count = instrCnt_q;
`else
   assign Cycle_Count = '0;
   assign Instr_Count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed scoreboard bench for multicycle_ctrl_fsm (4-bit and 6-bit opcode builds).
// Counter expectations follow MCCTRL_PERF_CNT_EN (zero when undefined).
module tb_multicycle_ctrl_fsm;

   localparam int CNT_W = 32;
`ifdef MCCTRL_PERF_CNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic [17:0] exp;
      bit          wide;
   } sbEntry_t;

   logic             clock = 1'b0;
   logic             resetN, resetN6;
   logic [3:0]       opcode;
   logic [5:0]       opcode6;
   logic             memReady, memReady6;

   logic             pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
   logic             memToReg, regDst, regWrite, aluSrcA, halted, trap;
   logic [1:0]       aluSrcB, aluOp, pcSource;
   logic [CNT_W-1:0] cycleCount, instrCount;

   logic             pcWrite6, pcWriteCond6, iorD6, memRead6, memWrite6, irWrite6;
   logic             memToReg6, regDst6, regWrite6, aluSrcA6, halted6, trap6;
   logic [1:0]       aluSrcB6, aluOp6, pcSource6;
   logic [CNT_W-1:0] cycleCount6, instrCount6;

   logic [17:0]      obs, obs6;
   sbEntry_t         sbQ[$];
   int               assertCount = 0;
   int               failCount   = 0;

   logic [17:0] eFetchRdy, eFetchWait, eDecode, eExecR, eExecI, eAluWbR, eAluWbI;
   logic [17:0] eMemAddr, eMemRd, eMemWb, eMemWr, eBranch, eJump, eHalt, eTrap;

   always #5 clock = ~clock;

   multicycle_ctrl_fsm #(.OPCODE_W(4), .CNT_W(CNT_W)) dut (
      .Clock(clock), .Reset_n(resetN), .Opcode(opcode), .Mem_Ready(memReady),
      .PCWrite(pcWrite), .PCWriteCond(pcWriteCond), .IorD(iorD),
      .MemRead(memRead), .MemWrite(memWrite), .IRWrite(irWrite),
      .MemToReg(memToReg), .RegDst(regDst), .RegWrite(regWrite),
      .ALUSrcA(aluSrcA), .ALUSrcB(aluSrcB), .ALUOp(aluOp), .PCSource(pcSource),
      .Halted(halted), .Trap(trap),
      .Cycle_Count(cycleCount), .Instr_Count(instrCount)
   );

   multicycle_ctrl_fsm #(.OPCODE_W(6), .CNT_W(CNT_W)) dut6 (
      .Clock(clock), .Reset_n(resetN6), .Opcode(opcode6), .Mem_Ready(memReady6),
      .PCWrite(pcWrite6), .PCWriteCond(pcWriteCond6), .IorD(iorD6),
      .MemRead(memRead6), .MemWrite(memWrite6), .IRWrite(irWrite6),
      .MemToReg(memToReg6), .RegDst(regDst6), .RegWrite(regWrite6),
      .ALUSrcA(aluSrcA6), .ALUSrcB(aluSrcB6), .ALUOp(aluOp6), .PCSource(pcSource6),
      .Halted(halted6), .Trap(trap6),
      .Cycle_Count(cycleCount6), .Instr_Count(instrCount6)
   );

   assign obs  = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                  regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, halted, trap};
   assign obs6 = {pcWrite6, pcWriteCond6, iorD6, memRead6, memWrite6, irWrite6, memToReg6,
                  regDst6, regWrite6, aluSrcA6, aluSrcB6, aluOp6, pcSource6, halted6, trap6};

   // Field order: pcw pcwc iord mr mw irw m2r rd rw asa asb aluop pcs halted trap
   function automatic logic [17:0] ctl(input logic pcw, pcwc, iord, mr, mw, irw, m2r,
                                       rd, rw, asa, input logic [1:0] asb, aop, pcs,
                                       input logic h, t);
      return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, h, t};
   endfunction

   // Drive one cycle of inputs just after the rising edge and record what the DUT must show.
   task automatic applyStimulus(input string tag, input logic ready, input logic [5:0] opc,
                                input logic [17:0] exp, input bit wide);
      @(posedge clock);
      #1;
      if (wide) begin
         opcode6   = opc;
         memReady6 = ready;
      end else begin
         opcode   = opc[3:0];
         memReady = ready;
      end
      sbQ.push_back('{tag, exp, wide});
   endtask

   // Pop the oldest expectation and compare against the DUT at the falling edge.
   task automatic checkOutput();
      sbEntry_t e;
      logic [17:0] o;
      @(negedge clock);
      assertCount++;
      if (sbQ.size() == 0) begin
         failCount++;
         $error("FAIL scoreboard_empty: observed 0 entries, expected at least 1");
      end else begin
         e = sbQ.pop_front();
         o = e.wide ? obs6 : obs;
         assert (o === e.exp) else begin
            failCount++;
            $error("FAIL %s: observed %05h expected %05h", e.tag, o, e.exp);
         end
      end
   endtask

   task automatic step(input string tag, input logic ready, input logic [5:0] opc,
                       input logic [17:0] exp, input bit wide = 1'b0);
      applyStimulus(tag, ready, opc, exp, wide);
      checkOutput();
   endtask

   task automatic checkCounters(input string tag, input int cyc, input int ins);
      logic [CNT_W-1:0] expC, expI;
      expC = PerfEn ? CNT_W'(cyc) : '0;
      expI = PerfEn ? CNT_W'(ins) : '0;
      assertCount++;
      assert (cycleCount === expC) else begin
         failCount++;
         $error("FAIL %s_cycles: observed %0d expected %0d", tag, cycleCount, expC);
      end
      assertCount++;
      assert (instrCount === expI) else begin
         failCount++;
         $error("FAIL %s_instrs: observed %0d expected %0d", tag, instrCount, expI);
      end
   endtask

   task automatic releaseReset(input bit wide);
      @(posedge clock);
      #1;
      if (wide) resetN6 = 1'b1;
      else      resetN  = 1'b1;
      sbQ.push_back('{wide ? "idle6" : "idle", 18'h0, wide});
      checkOutput();
   endtask

   initial begin
      eFetchRdy  = ctl(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      eFetchWait = ctl(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
      eDecode    = ctl(0,0,0,0,0,0,0,0,0,0,2'b10,2'b00,2'b00,0,0);
      eExecR     = ctl(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
      eExecI     = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      eAluWbR    = ctl(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
      eAluWbI    = ctl(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
      eMemAddr   = ctl(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
      eMemRd     = ctl(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      eMemWb     = ctl(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
      eMemWr     = ctl(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
      eBranch    = ctl(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
      eJump      = ctl(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0);
      eHalt      = ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
      eTrap      = ctl(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);

      resetN = 1'b0; resetN6 = 1'b0;
      opcode = 4'h0; opcode6 = 6'h00;
      memReady = 1'b1; memReady6 = 1'b1;

      $display("[TB] reset state");
      @(negedge clock);
      sbQ.push_back('{"reset", 18'h0, 1'b0});
      checkOutput();
      checkCounters("reset", 0, 0);
      releaseReset(1'b0);

      $display("[TB] RTYPE");
      step("r_fetch", 1, 6'h00, eFetchRdy);
      step("r_decode", 1, 6'h00, eDecode);
      step("r_exec", 1, 6'h00, eExecR);
      step("r_wb", 1, 6'h00, eAluWbR);

      $display("[TB] LW with memory stall");
      step("lw_fetch", 1, 6'h02, eFetchRdy);
      checkCounters("after_rtype", 4, 1);
      step("lw_decode", 1, 6'h02, eDecode);
      step("lw_addr", 1, 6'h02, eMemAddr);
      for (int i = 0; i < 3; i++) step($sformatf("lw_rd_wait%0d", i), 0, 6'h02, eMemRd);
      step("lw_rd_done", 1, 6'h02, eMemRd);
      step("lw_wb", 1, 6'h02, eMemWb);

      $display("[TB] ADDI with fetch stall");
      step("addi_fetch_wait", 0, 6'h01, eFetchWait);
      checkCounters("after_lw", 12, 2);
      step("addi_fetch", 1, 6'h01, eFetchRdy);
      step("addi_decode", 1, 6'h01, eDecode);
      step("addi_exec", 1, 6'h01, eExecI);
      step("addi_wb", 1, 6'h01, eAluWbI);

      $display("[TB] SW with write stall");
      step("sw_fetch", 1, 6'h03, eFetchRdy);
      checkCounters("after_addi", 17, 3);
      step("sw_decode", 1, 6'h03, eDecode);
      step("sw_addr", 1, 6'h03, eMemAddr);
      step("sw_wr_wait", 0, 6'h03, eMemWr);
      step("sw_wr_done", 1, 6'h03, eMemWr);

      $display("[TB] BEQ then J");
      step("beq_fetch", 1, 6'h04, eFetchRdy);
      checkCounters("after_sw", 22, 4);
      step("beq_decode", 1, 6'h04, eDecode);
      step("beq_branch", 1, 6'h04, eBranch);
      step("j_fetch", 1, 6'h05, eFetchRdy);
      checkCounters("after_beq", 25, 5);
      step("j_decode", 1, 6'h05, eDecode);
      step("j_jump", 1, 6'h05, eJump);

      $display("[TB] async reset during MEM_WR");
      step("sw2_fetch", 1, 6'h03, eFetchRdy);
      checkCounters("after_j", 28, 6);
      step("sw2_decode", 1, 6'h03, eDecode);
      step("sw2_addr", 1, 6'h03, eMemAddr);
      step("sw2_wr_wait", 0, 6'h03, eMemWr);
      @(posedge clock);
      #2;
      assertCount++;
      assert (memWrite === 1'b1) else begin
         failCount++;
         $error("FAIL sw2_wr_before_reset: observed %b expected 1", memWrite);
      end
      resetN = 1'b0;
      #1;
      assertCount++;
      assert (obs === 18'h0) else begin
         failCount++;
         $error("FAIL async_reset_outputs: observed %05h expected 00000", obs);
      end
      checkCounters("async_reset", 0, 0);
      memReady = 1'b1;
      @(posedge clock);
      releaseReset(1'b0);

      $display("[TB] illegal opcode 7");
      step("t_fetch", 1, 6'h07, eFetchRdy);
      step("t_decode", 1, 6'h07, eDecode);
      step("t_trap_first", 1, 6'h07, eTrap);
      checkCounters("trap_entry", 2, 0);
      for (int i = 0; i < 20; i++) step($sformatf("t_trap%0d", i), 1, 6'h00, eTrap);
      checkCounters("trap_frozen", 2, 0);

      $display("[TB] 6-bit opcode build");
      releaseReset(1'b1);
      step("w_fetch", 1, 6'h12, eFetchRdy, 1'b1);
      step("w_decode", 1, 6'h12, eDecode, 1'b1);
      step("w_trap0", 1, 6'h12, eTrap, 1'b1);
      step("w_trap1", 1, 6'h00, eTrap, 1'b1);
      @(posedge clock);
      #1 resetN6 = 1'b0;
      @(posedge clock);
      releaseReset(1'b1);
      step("h_fetch", 1, 6'h0F, eFetchRdy, 1'b1);
      step("h_decode", 1, 6'h0F, eDecode, 1'b1);
      for (int i = 0; i < 3; i++) step($sformatf("h_halt%0d", i), 1, 6'h00, eHalt, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Multi-cycle control sequencer that generalises the single-cycle control unit into a Moore FSM. It drives a shared-memory multi-cycle datapath, splitting each instruction into fetch, decode, execute, memory and writeback steps. It has a parametrised opcode width, a memory-ready stall handshake, sticky halt/trap states and optional performance counters. It sits beside the datapath in the CPU top, taking the IR opcode field and returning per-cycle control strobes.

## Interface
- OPCODE_W, 4, opcode field width (≥4); any opcode with bits above [3:0] set is illegal
- CNT_W, 32, width of performance counters
- Clock  in  1  rising-edge clock
- Reset_n  in  1  asynchronous, active-low reset
- Opcode  in  OPCODE_W  IR opcode field; sampled only in DECODE
- Mem_Ready  in  1  memory completes current read/write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath strobes/selects
- ALUSrcB  out  2  00 reg B, 01 constant 1, 10 sign-ext imm
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- Halted  out  1  HALT state reached (sticky)
- Trap  out  1  illegal opcode decoded (sticky)
- Cycle_Count, Instr_Count  out  CNT_W each  performance counters

## Operation
- Opcodes: 0 RTYPE, 1 ADDI, 2 LW, 3 SW, 4 BEQ, 5 J, F HALT; all others illegal.
- States: IDLE, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, ALU_WB, HALT, TRAP.
- IDLE: all outputs 0 → FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=Mem_Ready. Stay in FETCH while !Mem_Ready, else → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute). Opcode selects the next state:
  - RTYPE→EXEC_R; ADDI→EXEC_I; LW/SW→MEM_ADDR; BEQ→BRANCH; J→JUMP; HALT→HALT; illegal→TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALU_WB (RegDst=1).
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ALU_WB (RegDst=0).
- ALU_WB: RegWrite=1, MemToReg=0, RegDst per path (tracked in a 1-bit register) → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1; wait for Mem_Ready → MEM_WB.
- MEM_WB: RegWrite=1, MemToReg=1, RegDst=0 → FETCH.
- MEM_WR: MemWrite=1, IorD=1; wait for Mem_Ready → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 → FETCH.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- HALT/TRAP: absorbing. All strobes 0, Halted/Trap=1. Exit only via reset.
- Outputs not listed for a state are 0.

## Timing
- Outputs are a decode of the registered state. The only Mealy terms are IRWrite and PCWrite in FETCH, gated by Mem_Ready.
- Cycles per instruction with Mem_Ready tied high:
  - RTYPE/ADDI 4
  - LW 5
  - SW 4
  - BEQ/J 3
- Each cycle of Mem_Ready low in FETCH, MEM_RD or MEM_WR adds one cycle; MemRead/MemWrite stay asserted throughout.
- Reset assertion at any time immediately forces IDLE: all strobes, Halted, Trap and counters go to 0. The first FETCH occurs in the second cycle after Reset_n deasserts.
- Counters wrap modulo 2^CNT_W.

## Configuration
- MCCTRL_PERF_CNT_EN defined:
  - Cycle_Count increments every cycle outside IDLE, HALT and TRAP.
  - Instr_Count increments on each transition from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP to FETCH.
- MCCTRL_PERF_CNT_EN undefined: both ports are tied to 0 and no counter flops are built.

## Structure
- Package mc_ctrl_pkg:
  - state enum
  - opcode constants
  - ALUOp, ALUSrcB and PCSource encodings
  - packed control-word struct
- One combinational sub-module, mc_ctrl_decode: state (plus Mem_Ready and the RegDst flag) → control word. The FSM registers and counters stay in multicycle_ctrl_fsm.

## Test plan
- Reset, then Opcode=0 (RTYPE), Mem_Ready=1 → states FETCH, DECODE, EXEC_R, ALU_WB; RegWrite=1 and RegDst=1 in cycle 4 only; Instr_Count=1.
- LW with Mem_Ready low for 3 cycles in MEM_RD → MemRead, IorD held 4 cycles; MEM_WB has MemToReg=1; total 8 cycles.
- BEQ then J → PCWriteCond=1 with PCSource=01 in the BRANCH cycle, then PCWrite=1 with PCSource=10 in the JUMP cycle; 3 cycles each.
- Opcode=7 → TRAP in the cycle after DECODE; Trap=1 and all strobes 0 for 20 further cycles; Cycle_Count frozen.
- With OPCODE_W=6 and Opcode=6'h12 → TRAP. Opcode=6'h0F → HALT, Halted=1.
- Reset_n pulsed low mid-MEM_WR → MemWrite drops within the same cycle (async); all outputs 0; restart from IDLE.
